// File: rtl/spram_fb_pkg.sv
// Shared types and constants for the SP256K frame-buffer arbiter.
// Grant and power-state encodings, SPRAM geometry, FIFO entry layout.
package spram_fb_pkg;

  localparam int SPRAM_AW = 14;
  localparam int SPRAM_DW = 16;
  localparam logic [3:0] MASK_ALL = 4'b1111;

  typedef enum logic [1:0] {
    G_IDLE,
    G_READ,
    G_WRITE
  } grant_e;

  typedef enum logic [1:0] {
    P_ACTIVE,
    P_STANDBY,
    P_WAKE
  } pstate_e;

  typedef struct packed {
    logic [SPRAM_AW-1:0] addr;
    logic [SPRAM_DW-1:0] data;
  } wentry_t;

endpackage

// File: rtl/spram_fb_arbiter_if.sv
// Client-side bus of the frame-buffer arbiter: camera write
// handshake, VGA read request handshake and read data return.
// master = clients (packer + fetcher), slave = arbiter.
interface spram_fb_arbiter_if;
  import spram_fb_pkg::*;

  logic                wr_valid;
  logic                wr_ready;
  logic [SPRAM_AW-1:0] wr_addr;
  logic [SPRAM_DW-1:0] wr_data;
  logic                rd_req_valid;
  logic                rd_req_ready;
  logic [SPRAM_AW-1:0] rd_addr;
  logic                rd_data_valid;
  logic [SPRAM_DW-1:0] rd_data;

  modport master (
    output wr_valid, wr_addr, wr_data,
    output rd_req_valid, rd_addr,
    input  wr_ready, rd_req_ready,
    input  rd_data_valid, rd_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_addr,
    output wr_ready, rd_req_ready,
    output rd_data_valid, rd_data
  );

endinterface

// File: rtl/spram_fb_wfifo.sv
// Synchronous write FIFO of {addr,data} entries with occupancy.
// Ports: CLK, RST, push/push_entry, pop, head, level.
module spram_fb_wfifo
  import spram_fb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int LW = PW + 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          push,
  input  wentry_t       push_entry,
  input  logic          pop,
  output wentry_t       head,
  output logic [LW-1:0] level
);

  wentry_t mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= push_entry;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/spram_fb_arbiter.sv
// Shares one SP256K between camera writes (FIFO-buffered) and VGA
// reads. Ports: CLK, RST, bus (client if), fifo_level, spram_* pins.
// Optional macro SPRAM_FB_STDBY_EN adds idle standby/wake states.
module spram_fb_arbiter
  import spram_fb_pkg::*;
#(
  parameter int WFIFO_DEPTH  = 8,
  parameter int URGENT_LEVEL = 6,
  localparam int LW = $clog2(WFIFO_DEPTH) + 1
) (
  input  logic                CLK,
  input  logic                RST,
  spram_fb_arbiter_if.slave   bus,
  output logic [LW-1:0]       fifo_level,
  output logic [SPRAM_AW-1:0] spram_ad,
  output logic [SPRAM_DW-1:0] spram_di,
  output logic [3:0]          spram_maskwe,
  output logic                spram_we,
  output logic                spram_cs,
  output logic                spram_stdby,
  output logic                spram_sleep,
  output logic                spram_pwroff_n,
  input  logic [SPRAM_DW-1:0] spram_do
);

  grant_e  grant;
  pstate_e state;
  wentry_t head;
  wentry_t push_entry;
  logic    urgent;
  logic    active;
  logic    has_data;
  logic    push;
  logic    pop;
  logic    rvalid_q;

  assign urgent   = fifo_level >= LW'(URGENT_LEVEL);
  assign has_data = fifo_level != '0;
  assign active   = state == P_ACTIVE;

  assign bus.wr_ready     = fifo_level < LW'(WFIFO_DEPTH);
  assign bus.rd_req_ready = active && !urgent;

  assign push = bus.wr_valid && bus.wr_ready;
  assign pop  = grant == G_WRITE;
  assign push_entry = '{addr: bus.wr_addr, data: bus.wr_data};

  spram_fb_wfifo #(
    .DEPTH(WFIFO_DEPTH)
  ) u_wfifo (
    .CLK        (CLK),
    .RST        (RST),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .level      (fifo_level)
  );

`ifdef SPRAM_FB_STDBY_EN
  pstate_e    state_nx;
  logic [3:0] idle_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= P_ACTIVE;
      idle_cnt <= '0;
    end else begin
      state <= state_nx;
      if (active && grant == G_IDLE)
        idle_cnt <= idle_cnt + 4'd1;
      else
        idle_cnt <= '0;
    end
  end

  // idle_cnt==15 plus this idle cycle is the 16th in a row
  always_comb begin
    state_nx = state;
    unique case (state)
      P_ACTIVE:
        if (grant == G_IDLE && idle_cnt == 4'hF)
          state_nx = P_STANDBY;
      P_STANDBY:
        if (bus.rd_req_valid || bus.wr_valid)
          state_nx = P_WAKE;
      P_WAKE:
        state_nx = P_ACTIVE;
      default:
        state_nx = P_ACTIVE;
    endcase
  end

  assign spram_stdby = state == P_STANDBY;
`else
  assign state       = P_ACTIVE;
  assign spram_stdby = 1'b0;
`endif

  // No access is issued while RST is held, so the RAM is untouched.
  always_comb begin
    grant = G_IDLE;
    if (active && !RST) begin
      unique case (1'b1)
        urgent:
          grant = G_WRITE;
        !urgent && bus.rd_req_valid:
          grant = G_READ;
        !urgent && !bus.rd_req_valid && has_data:
          grant = G_WRITE;
        default:
          grant = G_IDLE;
      endcase
    end
  end

  always_comb begin
    spram_cs     = 1'b0;
    spram_we     = 1'b0;
    spram_maskwe = '0;
    spram_ad     = bus.rd_addr;
    spram_di     = head.data;
    unique case (grant)
      G_WRITE: begin
        spram_cs     = 1'b1;
        spram_we     = 1'b1;
        spram_maskwe = MASK_ALL;
        spram_ad     = head.addr;
      end
      G_READ: begin
        spram_cs = 1'b1;
      end
      default: begin
        spram_cs = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) rvalid_q <= 1'b0;
    else     rvalid_q <= grant == G_READ;
  end

  // A reset landing on the data cycle suppresses the pulse at once.
  assign bus.rd_data_valid = rvalid_q && !RST;
  assign bus.rd_data = bus.rd_data_valid ? spram_do : '0;

  assign spram_sleep    = 1'b0;
  assign spram_pwroff_n = 1'b1;

endmodule

// File: tb/tb_spram_fb_arbiter.sv
// Testbench for spram_fb_arbiter: SP256K behavioural RAM, queue-based
// reference model, directed plus randomized steps, and a full-FIFO run.
module tb_spram_fb_arbiter;
  import spram_fb_pkg::*;

  localparam int D   = 8;
  localparam int URG = 6;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic rst2 = 1'b1;
  always #5 CLK = ~CLK;

  spram_fb_arbiter_if bus ();
  spram_fb_arbiter_if bus2 ();

  logic [3:0]  lvl, lvl2;
  logic [13:0] ad, ad2;
  logic [15:0] di, di2;
  logic [3:0]  mask, mask2;
  logic        we, we2, cs, cs2;
  logic        stdby, stdby2, slp, slp2, pwr, pwr2;
  logic [15:0] dout;
  logic [15:0] dout2 = 16'h0;

  spram_fb_arbiter u_dut (
    .CLK(CLK), .RST(RST), .bus(bus), .fifo_level(lvl),
    .spram_ad(ad), .spram_di(di), .spram_maskwe(mask),
    .spram_we(we), .spram_cs(cs), .spram_stdby(stdby),
    .spram_sleep(slp), .spram_pwroff_n(pwr), .spram_do(dout)
  );

  spram_fb_arbiter #(.URGENT_LEVEL(8)) u_full (
    .CLK(CLK), .RST(rst2), .bus(bus2), .fifo_level(lvl2),
    .spram_ad(ad2), .spram_di(di2), .spram_maskwe(mask2),
    .spram_we(we2), .spram_cs(cs2), .spram_stdby(stdby2),
    .spram_sleep(slp2), .spram_pwroff_n(pwr2), .spram_do(dout2)
  );

  // SP256K model: nibble write mask, registered read data
  bit [15:0] ram [16384];
  always @(posedge CLK) begin : ram_model
    logic [15:0] w;
    if (cs) begin
      if (we) begin
        w = ram[ad];
        for (int k = 0; k < 4; k++)
          if (mask[k]) w[4*k +: 4] = di[4*k +: 4];
        ram[ad] <= w;
      end else begin
        dout <= ram[ad];
      end
    end
  end

  typedef struct {
    logic [13:0] a;
    logic [15:0] d;
  } wr_t;

  wr_t         q[$];
  bit [15:0]   refmem [16384];
  bit          prev_rd;
  logic [15:0] prev_data;
  int          pst;
  int          idle_n;
  int          ntests;
  int          nfail;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one clock: drive, check against model, advance model
  task automatic step(bit r, bit wv, logic [13:0] wa,
                      logic [15:0] wd, bit rv,
                      logic [13:0] ra);
    int g;
    int le;
    bit urg;
    bit act;
    bit vexp;
    @(negedge CLK);
    RST = r;
    bus.wr_valid = wv;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.rd_req_valid = rv;
    bus.rd_addr = ra;
    #1;
    le = q.size();
    urg = le >= URG;
    act = pst == 0;
    g = 0;
    if (!r && act) begin
      if (urg) g = 2;
      else if (rv) g = 1;
      else if (le > 0) g = 2;
    end
    vexp = prev_rd && !r;
    chk("fifo_level", 32'(lvl), 32'(le));
    chk("wr_ready", 32'(bus.wr_ready), 32'(le < D));
    chk("rd_req_ready", 32'(bus.rd_req_ready),
        32'(act && !urg));
    chk("spram_cs", 32'(cs), 32'(g != 0));
    chk("spram_we", 32'(we), 32'(g == 2));
    chk("spram_stdby", 32'(stdby), 32'(pst == 1));
    if (g == 2) begin
      chk("wr_ad", 32'(ad), 32'(q[0].a));
      chk("wr_di", 32'(di), 32'(q[0].d));
      chk("wr_mask", 32'(mask), 32'hF);
    end
    if (g == 1) begin
      chk("rd_ad", 32'(ad), 32'(ra));
      chk("rd_mask", 32'(mask), 32'h0);
    end
    chk("rd_data_valid", 32'(bus.rd_data_valid), 32'(vexp));
    chk("rd_data", 32'(bus.rd_data),
        vexp ? 32'(prev_data) : 32'h0);
    if (r) begin
      q.delete();
      prev_rd = 1'b0;
      pst = 0;
      idle_n = 0;
    end else begin
      if (g == 2) begin
        refmem[q[0].a] = q[0].d;
        void'(q.pop_front());
      end
      if (wv && le < D) q.push_back('{a: wa, d: wd});
      prev_rd = g == 1;
      if (g == 1) prev_data = refmem[ra];
`ifdef SPRAM_FB_STDBY_EN
      case (pst)
        0: begin
          if (g == 0) begin
            idle_n++;
            if (idle_n == 16) begin
              pst = 1;
              idle_n = 0;
            end
          end else begin
            idle_n = 0;
          end
        end
        1: if (rv || wv) pst = 2;
        default: pst = 0;
      endcase
`endif
    end
  endtask

  task automatic idle();
    step(0, 0, 14'h0, 16'h0, 0, 14'h0);
  endtask

  logic [29:0] wlog[$];
  int          pushed;

  initial begin
    ntests = 0;
    nfail = 0;
    prev_rd = 0;
    prev_data = '0;
    pst = 0;
    idle_n = 0;
    bus.wr_valid = 0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.rd_req_valid = 0;
    bus.rd_addr = '0;
    bus2.wr_valid = 0;
    bus2.wr_addr = '0;
    bus2.wr_data = '0;
    bus2.rd_req_valid = 0;
    bus2.rd_addr = '0;
    repeat (3) @(posedge CLK);

    // full FIFO with reads always winning below level 8
    pushed = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      rst2 = 0;
      bus2.rd_req_valid = 1;
      bus2.wr_valid = 1;
      bus2.wr_addr = 14'h100 + 14'(pushed);
      bus2.wr_data = 16'hA000 + 16'(pushed);
      #1;
      chk("full_level", 32'(lvl2), c <= 8 ? c : 7);
      chk("full_wr_ready", 32'(bus2.wr_ready), 32'(c != 8));
      if (c == 0) begin
        chk("sleep", 32'(slp2), 32'h0);
        chk("pwroff_n", 32'(pwr2), 32'h1);
      end
      if (c == 8) begin
        chk("full_cs", 32'(cs2), 32'h1);
        chk("full_we", 32'(we2), 32'h1);
        chk("full_ad", 32'(ad2), 32'h100);
      end
      if (cs2 && we2) wlog.push_back({ad2, di2});
      if (bus2.wr_ready) pushed++;
    end
    chk("full_pushed", 32'(pushed), 32'd9);
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      bus2.wr_valid = 0;
      bus2.rd_req_valid = 0;
      #1;
      if (cs2 && we2) wlog.push_back({ad2, di2});
    end
    chk("full_wr_count", 32'(wlog.size()), 32'd9);
    for (int k = 0; k < 9 && k < wlog.size(); k++)
      chk("full_wr_order", 32'(wlog[k]),
          32'({14'h100 + 14'(k), 16'hA000 + 16'(k)}));
    @(negedge CLK);
    rst2 = 1;

    // reset state
    step(0, 0, 14'h0, 16'h0, 0, 14'h0);
    chk("reset_level", 32'(lvl), 32'h0);
    chk("reset_cs", 32'(cs), 32'h0);

    // single write drains with no read traffic
    step(0, 1, 14'h0010, 16'hBEEF, 0, 14'h0);
    idle();
    chk("w1_cs", 32'(cs), 32'h1);
    chk("w1_ad", 32'(ad), 32'h0010);
    chk("w1_di", 32'(di), 32'hBEEF);
    idle();
    chk("w1_level", 32'(lvl), 32'h0);

    // read back
    step(0, 0, 14'h0, 16'h0, 1, 14'h0010);
    chk("r1_ready", 32'(bus.rd_req_ready), 32'h1);
    idle();
    chk("r1_data", 32'(bus.rd_data), 32'hBEEF);

    // reads held while writes pile up to the urgent level
    for (int i = 0; i < 10; i++)
      step(0, 1, 14'h20 + 14'(i), 16'(i * 7 + 3),
           1, 14'h20);
    for (int i = 0; i < 4; i++)
      step(0, 0, 14'h0, 16'h0, 1, 14'h21);
    repeat (8) idle();

    // reset on the data cycle of an accepted read
    for (int i = 0; i < 3; i++)
      step(0, 1, 14'h30 + 14'(i), 16'h5A00, 1, 14'h10);
    step(0, 0, 14'h0, 16'h0, 1, 14'h10);
    step(1, 0, 14'h0, 16'h0, 0, 14'h0);
    chk("rst_valid", 32'(bus.rd_data_valid), 32'h0);
    idle();
    chk("rst_level", 32'(lvl), 32'h0);
    chk("rst_cs", 32'(cs), 32'h0);

`ifdef SPRAM_FB_STDBY_EN
    repeat (17) idle();
    chk("stdby_on", 32'(stdby), 32'h1);
    step(0, 0, 14'h0, 16'h0, 1, 14'h10);
    step(0, 0, 14'h0, 16'h0, 1, 14'h10);
    chk("stdby_wake", 32'(stdby), 32'h0);
    step(0, 0, 14'h0, 16'h0, 1, 14'h10);
    chk("stdby_ready", 32'(bus.rd_req_ready), 32'h1);
`endif

    // randomized phases, including long idle stretches
    for (int i = 0; i < 800; i++) begin
      int ph;
      bit r;
      bit wv;
      bit rv;
      ph = (i / 40) % 4;
      r = $urandom_range(0, 149) == 0;
      wv = $urandom_range(0, 2) < ph;
      rv = ph != 0 && $urandom_range(0, 1) == 1;
      step(r, wv, 14'($urandom_range(0, 31)),
           16'($urandom), rv, 14'($urandom_range(0, 31)));
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
